// File: rtl/ifetch_wb_master.sv
// Instruction-fetch Wishbone master: turns per-cycle fetch requests into single
// classic Wishbone reads, stalls the pipeline until ack, and aborts hung fetches.
module ifetch_wb_master #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        cyc_q;
    logic [31:0] rd_buf;
    logic [7:0]  tmo_cnt;

    logic        stallreq;
    logic [31:0] cpu_data;
    logic        fetch_start;
    logic        fetch_done;
    logic        fetch_abort;
    logic [31:0] buf_val;

    // Only the if-stage stall bit matters to this block.
    logic        unused_stall;
    assign unused_stall = ^{stall_i[5:2], stall_i[0]};

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        stallreq    = 1'b0;
        cpu_data    = NOP_WORD;
        fetch_start = 1'b0;
        fetch_done  = 1'b0;
        fetch_abort = 1'b0;
        buf_val     = wb_dat_i;

        case (state)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    stallreq    = 1'b1;
                    fetch_start = 1'b1;
                    state_nxt   = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (wb_ack_i) begin
                    cpu_data   = wb_dat_i;
                    fetch_done = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    // A hung fetch completes as if the slave had returned a NOP.
                    buf_val     = NOP_WORD;
                    fetch_done  = 1'b1;
                    fetch_abort = 1'b1;
                end else begin
                    stallreq = 1'b1;
                end
                if (fetch_done) begin
                    state_nxt = stall_i[1] ? WAIT_STALL : IDLE;
                end
            end
            WAIT_STALL: begin
                cpu_data = rd_buf;
                if (!stall_i[1] || flush_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= IDLE;
            cyc_q    <= 1'b0;
            wb_adr_o <= '0;
            rd_buf   <= '0;
            tmo_cnt  <= '0;
            err_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_o <= fetch_abort;
            if (fetch_start) begin
                wb_adr_o <= cpu_addr_i;
                cyc_q    <= 1'b1;
                tmo_cnt  <= '0;
            end else if (state == BUSY) begin
                if (state_nxt != BUSY) begin
                    cyc_q <= 1'b0;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
            if (fetch_done) begin
                rd_buf <= buf_val;
            end
        end
    end

    // Reset forces the state to IDLE, but IDLE still reflects cpu_ce_i, so gate it.
    assign stallreq_o = stallreq & wb_rst_i;
    assign cpu_data_o = cpu_data;

    assign wb_stb_o = cyc_q;
    assign wb_cyc_o = cyc_q;
    assign wb_sel_o = {4{cyc_q}};
    assign wb_we_o  = 1'b0;
    assign wb_dat_o = '0;

endmodule

// File: doc/ifetch_wb_master.md
# ifetch_wb_master

Instruction-fetch Wishbone master between the CPU pc/if stage and the instruction ROM Wishbone slave. It turns the pipeline's per-cycle fetch request (chip-enable plus PC) into classic single Wishbone read cycles, stalls the pipeline until the slave acknowledges, and holds the fetched word while the pipeline is stalled for other reasons. A watchdog aborts fetches the slave never acknowledges and returns a NOP instead.

## Interface
- TIMEOUT, 16: BUSY cycles without ack before abort; range 2..255.
- NOP_WORD, 32'h0000_0000: instruction word returned on abort or flush.
---
- wb_clk_i  in  1  single clock; all state on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low (0 = reset).
- cpu_ce_i  in  1  fetch request valid.
- cpu_addr_i  in  32  fetch byte address (PC); bits [1:0] are passed through unchanged.
- cpu_data_o  out  32  fetched instruction to if/id.
- stall_i  in  6  pipeline stall vector; stall_i[1] = if stage stalled.
- flush_i  in  1  pipeline flush (exception/eret); abandons the fetch in progress.
- stallreq_o  out  1  combinational fetch-stall request to the stall controller.
- err_o  out  1  one-cycle pulse when a fetch times out.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  always 0; the block never writes.
- wb_sel_o  out  4  4'hF during a cycle, else 0.
- wb_we_o  out  1  always 0.
- wb_stb_o / wb_cyc_o  out  1  strobe and cycle; always equal.
- wb_dat_i  in  32  read data, sampled only with wb_ack_i in BUSY.
- wb_ack_i  in  1  slave acknowledge.

## Operation
- Three states: IDLE, BUSY, WAIT_STALL. Reset puts the block in IDLE.
- Registers: rd_buf[31:0], tmo_cnt[7:0].
- Reset values: wb_adr_o=0, wb_sel_o=0, wb_stb_o=0, wb_cyc_o=0, rd_buf=0, tmo_cnt=0, err_o=0. stallreq_o=0 and cpu_data_o=NOP_WORD while in reset.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: register wb_adr_o=cpu_addr_i, cyc=stb=1, sel=4'hF, tmo_cnt=0, and go to BUSY. stallreq_o=1 this cycle.
  - Otherwise stay in IDLE with stallreq_o=0.
  - cpu_data_o=NOP_WORD.
- BUSY (priority order):
  1. flush_i=1: drop cyc/stb/sel, go to IDLE, stallreq_o=0, cpu_data_o=NOP_WORD. A later ack is ignored.
  2. wb_ack_i=1: cpu_data_o=wb_dat_i combinationally, stallreq_o=0, rd_buf<=wb_dat_i. Drop cyc/stb/sel. Next state is WAIT_STALL if stall_i[1]=1, else IDLE.
  3. tmo_cnt=TIMEOUT-1: treated as an ack carrying NOP_WORD (rd_buf<=NOP_WORD), with err_o<=1 for the next cycle.
  4. Otherwise: stallreq_o=1, tmo_cnt increments, cpu_data_o=NOP_WORD.
- WAIT_STALL:
  - stallreq_o=0, cpu_data_o=rd_buf.
  - Return to IDLE when stall_i[1]=0 or flush_i=1.
- wb_ack_i is ignored in IDLE and WAIT_STALL, so a stale ack from a registered-ack slave is harmless.
- Byte order: the slave delivers CPU byte order; the data path passes through untouched.

## Timing
- Request at cycle n (IDLE): stb is high from n+1.
- Single-wait-state slave (ack at n+2): data valid on cpu_data_o at n+2, stallreq_o high for n and n+1, low at n+2.
- stb falls at the edge ending the ack cycle.
- At least one IDLE cycle separates consecutive Wishbone cycles. Throughput is therefore at most one fetch per (slave latency + 1) cycles.
- Abort: stb is high for exactly TIMEOUT cycles. err_o is high in the cycle after the last of them.
- Async reset mid-BUSY: cyc/stb drop immediately (no clock needed). The fetch is lost and is re-issued after reset.
- Flush and ack in the same cycle: flush wins, data is discarded, no rd_buf update.
- cpu_ce_i=0 in BUSY: the cycle completes normally; cpu_ce_i is checked only in IDLE.

## Test plan
- Reset low mid-BUSY -> cyc/stb/sel=0 asynchronously; after release, state is IDLE and stallreq_o=0.
- cpu_ce_i=1, addr 0x0000_0010, slave acks 2 cycles after stb with 0x2408_0005 -> one-cycle-wide ack, cpu_data_o=0x2408_0005 in the ack cycle, stallreq_o high exactly 2 cycles, stb low the next cycle.
- Back-to-back fetches 0x0, 0x4, 0x8 with a registered-ack slave that re-asserts ack once after stb falls -> three distinct cycles, each separated by ≥1 idle cycle, no spurious data, correct addresses.
- Ack arrives while stall_i[1]=1 for 3 cycles -> cpu_data_o holds the acked word all 3 cycles with stallreq_o=0; the next request starts after stall_i[1] falls.
- flush_i pulses in BUSY 1 cycle before ack -> stb drops, the late ack is ignored, cpu_data_o=NOP_WORD, the next fetch uses the new cpu_addr_i.
- Slave never acks, TIMEOUT=16 -> stb high exactly 16 cycles, then a one-cycle err_o pulse, cpu_data_o=0x0000_0000, return to IDLE.
